// File: rtl/mips32_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mips32_mem_arbiter
//  Description : Shares the single-port 1024x32 unified memory between the
//                MEM-stage data port, the IF-stage instruction fetch and the
//                debug loader. Each access runs IDLE -> ISSUE -> CAPTURE:
//                  IDLE    arbitrate, latch the winner's access onto mem_*
//                  ISSUE   mem_en high for exactly this cycle
//                  CAPTURE return mem_rdata and pulse the owner's ack
//                A request seen in IDLE cycle N is acknowledged in cycle N+2.
//                Fixed priority is data > fetch > dbg. While halted is high,
//                data and fetch requests are ignored at arbitration.
//  Option      : define ARB_STARVE_GUARD_EN to add wait counters for fetch
//                and dbg. A requester left waiting STARVE_LIMIT arbitrations
//                is granted ahead of data (fetch ahead of dbg if both are
//                starved).
//  Ports       : clk1, rst_n (sync, active low), halted
//                data_{req,we,addr,wdata} -> data_{ack,rdata}
//                fetch_{req,addr}         -> fetch_{ack,rdata}
//                dbg_{req,we,addr,wdata}  -> dbg_{ack,rdata}
//                mem_{en,we,addr,wdata} (registered), mem_rdata (sync read)
//  Revision    : 1.0 - initial release
// ============================================================================
module mips32_mem_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              halted,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_ack,
    output logic [DATA_W-1:0] data_rdata,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ack,
    output logic [DATA_W-1:0] fetch_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_DATA  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DBG   = 2'd2
    } owner_t;

    if (STARVE_LIMIT < 1) begin : g_limit_check
        $error("STARVE_LIMIT must be at least 1");
    end

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic                grant;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                mem_en_q, mem_we_q, wr_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;

    // Halt masks only the pipeline requesters; the debug loader keeps access.
    logic data_act, fetch_act, dbg_act;
    assign data_act  = data_req  & ~halted;
    assign fetch_act = fetch_req & ~halted;
    assign dbg_act   = dbg_req;

    logic fetch_force, dbg_force;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] fetch_cnt_q, dbg_cnt_q;
    logic             fetch_wait, dbg_wait;

    assign fetch_force = fetch_act & (fetch_cnt_q == LIMIT);
    assign dbg_force   = dbg_act   & (dbg_cnt_q   == LIMIT);

    // A requester "waits" in an IDLE cycle where it is active but not chosen.
    assign fetch_wait = (state_q == S_IDLE) & fetch_act & ~(grant & (owner_d == OWN_FETCH));
    assign dbg_wait   = (state_q == S_IDLE) & dbg_act   & ~(grant & (owner_d == OWN_DBG));

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            dbg_cnt_q   <= '0;
        end else begin
            if (fetch_ack)
                fetch_cnt_q <= '0;
            else if (fetch_wait && (fetch_cnt_q != LIMIT))
                fetch_cnt_q <= fetch_cnt_q + 1'b1;

            if (dbg_ack)
                dbg_cnt_q <= '0;
            else if (dbg_wait && (dbg_cnt_q != LIMIT))
                dbg_cnt_q <= dbg_cnt_q + 1'b1;
        end
    end
`else
    assign fetch_force = 1'b0;
    assign dbg_force   = 1'b0;
`endif

    // Next-state and arbitration. Starved requesters are checked before the
    // fixed-priority chain so they can overtake a continuously busy data port.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        grant     = 1'b0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        case (state_q)
            S_IDLE: begin
                if (fetch_force) begin
                    grant = 1'b1; owner_d = OWN_FETCH;
                end else if (dbg_force) begin
                    grant = 1'b1; owner_d = OWN_DBG;
                end else if (data_act) begin
                    grant = 1'b1; owner_d = OWN_DATA;
                end else if (fetch_act) begin
                    grant = 1'b1; owner_d = OWN_FETCH;
                end else if (dbg_act) begin
                    grant = 1'b1; owner_d = OWN_DBG;
                end
                if (grant)
                    state_d = S_ISSUE;
            end
            S_ISSUE:   state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        case (owner_d)
            OWN_DATA: begin
                sel_we = data_we; sel_addr = data_addr; sel_wdata = data_wdata;
            end
            OWN_FETCH: begin
                sel_addr = fetch_addr;
            end
            default: begin
                sel_we = dbg_we; sel_addr = dbg_addr; sel_wdata = dbg_wdata;
            end
        endcase
    end

    // mem_en/mem_we rise only on a grant, so they are high during ISSUE alone.
    // wr_q remembers the access type so a write ack returns zero data.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_DATA;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            wr_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            mem_en_q <= grant;
            mem_we_q <= grant & sel_we;
            if (grant) begin
                wr_q        <= sel_we;
                mem_addr_q  <= sel_addr;
                mem_wdata_q <= sel_wdata;
            end
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Memory data arrives in CAPTURE, so ack and read data come straight from
    // the state register and mem_rdata rather than through another flop.
    logic capture;
    assign capture   = (state_q == S_CAPTURE);
    assign data_ack  = capture & (owner_q == OWN_DATA);
    assign fetch_ack = capture & (owner_q == OWN_FETCH);
    assign dbg_ack   = capture & (owner_q == OWN_DBG);

    assign data_rdata  = (data_ack  & ~wr_q) ? mem_rdata : '0;
    assign fetch_rdata = fetch_ack           ? mem_rdata : '0;
    assign dbg_rdata   = (dbg_ack   & ~wr_q) ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mips32_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mips32_mem_arbiter
//  Description : Directed bench for mips32_mem_arbiter with a behavioural
//                1024x32 synchronous memory, an expected-ack scoreboard and
//                a negedge monitor. Builds with or without ARB_STARVE_GUARD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips32_mem_arbiter;

    localparam int ADDR_W       = 10;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 4;
    localparam int P_DATA  = 0;
    localparam int P_FETCH = 1;
    localparam int P_DBG   = 2;
    localparam int TMO     = 50;

    localparam logic [31:0] V_A5 = 32'hDEADBEEF;
    localparam logic [31:0] V_A1 = 32'h11112222;
    localparam logic [31:0] V_A7 = 32'h07700770;
    localparam logic [31:0] V_SW = 32'h12345678;
    localparam logic [31:0] V_DB = 32'hCAFEF00D;

`ifdef ARB_STARVE_GUARD_EN
    localparam int N_DATA_BEFORE_DBG = STARVE_LIMIT;
`else
    localparam int N_DATA_BEFORE_DBG = 6;
`endif

    logic              clk1 = 1'b0;
    logic              rst_n = 1'b0;
    logic              halted = 1'b0;
    logic              data_req = 1'b0, data_we = 1'b0;
    logic [ADDR_W-1:0] data_addr = '0;
    logic [DATA_W-1:0] data_wdata = '0;
    logic              data_ack;
    logic [DATA_W-1:0] data_rdata;
    logic              fetch_req = 1'b0;
    logic [ADDR_W-1:0] fetch_addr = '0;
    logic              fetch_ack;
    logic [DATA_W-1:0] fetch_rdata;
    logic              dbg_req = 1'b0, dbg_we = 1'b0;
    logic [ADDR_W-1:0] dbg_addr = '0;
    logic [DATA_W-1:0] dbg_wdata = '0;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    mips32_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk1(clk1), .rst_n(rst_n), .halted(halted),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_ack(data_ack), .data_rdata(data_rdata),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ack(fetch_ack), .fetch_rdata(fetch_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk1 = ~clk1;

    int cyc = 0;
    always @(posedge clk1) cyc <= cyc + 1;

    // Behavioural synchronous-read memory macro.
    logic [DATA_W-1:0] mem [0:1023];
    always @(posedge clk1) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0]  port;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    task automatic expect_ack(input int p, input logic [31:0] d);
        exp_q.push_back(exp_t'{port: 2'(p), data: d});
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic port_ack(input int p);
        case (p)
            P_DATA:  return data_ack;
            P_FETCH: return fetch_ack;
            default: return dbg_ack;
        endcase
    endfunction

    // Monitor: every ack is popped against the scoreboard in order.
    exp_t        mon_e;
    int          mon_p;
    logic [31:0] mon_d;
    int          dbg_ack_cnt = 0;
    always @(negedge clk1) begin
        if (data_ack === 1'b1 || fetch_ack === 1'b1 || dbg_ack === 1'b1) begin
            checks++;
            if (32'(data_ack) + 32'(fetch_ack) + 32'(dbg_ack) != 32'd1) begin
                failures++;
                $display("FAIL onehot_ack got=%b%b%b required=one ack", data_ack, fetch_ack, dbg_ack);
            end
            if (data_ack)       begin mon_p = P_DATA;  mon_d = data_rdata;  end
            else if (fetch_ack) begin mon_p = P_FETCH; mon_d = fetch_rdata; end
            else                begin mon_p = P_DBG;   mon_d = dbg_rdata;   end
            if (dbg_ack) dbg_ack_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_ack got=port%0d data=%h required=no ack", mon_p, mon_d);
            end else begin
                mon_e = exp_q.pop_front();
                if (int'(mon_e.port) != mon_p || mon_e.data !== mon_d) begin
                    failures++;
                    $display("FAIL sb_ack got=port%0d data=%h required=port%0d data=%h",
                             mon_p, mon_d, mon_e.port, mon_e.data);
                end
            end
        end
    end

    // Wait (bounded) for an ack on one port; leaves time at that negedge.
    task automatic wait_ack(input int p, output int tack);
        tack = -1;
        for (int n = 0; n < TMO; n++) begin
            @(negedge clk1);
            if (port_ack(p) === 1'b1) begin
                tack = cyc;
                break;
            end
        end
        checks++;
        if (tack < 0) begin
            failures++;
            $display("FAIL ack_timeout got=no ack on port%0d required=ack within %0d cycles", p, TMO);
        end
    endtask

    // Issue one request from an IDLE-aligned point and drop it after the ack.
    task automatic do_req(input int p, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] wd, output int t0, output int tack);
        case (p)
            P_DATA:  begin data_we = we; data_addr = a; data_wdata = wd; data_req = 1'b1; end
            P_FETCH: begin fetch_addr = a; fetch_req = 1'b1; end
            default: begin dbg_we = we; dbg_addr = a; dbg_wdata = wd; dbg_req = 1'b1; end
        endcase
        t0 = cyc;
        wait_ack(p, tack);
        @(posedge clk1); #1;
        case (p)
            P_DATA:  data_req  = 1'b0;
            P_FETCH: fetch_req = 1'b0;
            default: dbg_req   = 1'b0;
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0a, ta, t0b, tb, tprev, tcur, nack, dbg_before;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA5000000 | 32'(i);
        mem[5] = V_A5;
        mem[1] = V_A1;
        mem[7] = V_A7;

        // 1. Reset with every request high.
        data_req = 1'b1; fetch_req = 1'b1; dbg_req = 1'b1;
        repeat (2) begin
            @(negedge clk1);
            chk("rst_acks", {29'd0, data_ack, fetch_ack, dbg_ack}, 32'd0);
            chk("rst_mem_en", 32'(mem_en), 32'd0);
            chk("rst_rdata", data_rdata | fetch_rdata | dbg_rdata, 32'd0);
        end
        @(posedge clk1); #1;
        data_req = 1'b0; fetch_req = 1'b0; dbg_req = 1'b0;
        rst_n = 1'b1;

        // 2. Single fetch: timing of mem_en/mem_addr and ack.
        expect_ack(P_FETCH, V_A5);
        fetch_addr = 10'd5; fetch_req = 1'b1; t0a = cyc;
        @(negedge clk1);
        chk("t2_idle_mem_en", 32'(mem_en), 32'd0);
        @(negedge clk1);
        chk("t2_issue_mem_en", 32'(mem_en), 32'd1);
        chk("t2_issue_mem_addr", 32'(mem_addr), 32'd5);
        chk("t2_issue_mem_we", 32'(mem_we), 32'd0);
        @(negedge clk1);
        chk("t2_fetch_ack", 32'(fetch_ack), 32'd1);
        chk("t2_fetch_rdata", fetch_rdata, V_A5);
        chk("t2_latency", 32'(cyc - t0a), 32'd2);
        @(posedge clk1); #1;
        fetch_req = 1'b0;

        // 3. Collision: store wins, fetch 3 cycles later, then read back.
        expect_ack(P_DATA, 32'd0);
        expect_ack(P_FETCH, V_A5);
        fork
            do_req(P_DATA, 1'b1, 10'd3, V_SW, t0a, ta);
            do_req(P_FETCH, 1'b0, 10'd5, 32'd0, t0b, tb);
        join
        chk("t3_data_latency", 32'(ta - t0a), 32'd2);
        chk("t3_fetch_after_data", 32'(tb - ta), 32'd3);
        expect_ack(P_DATA, V_SW);
        do_req(P_DATA, 1'b0, 10'd3, 32'd0, t0a, ta);
        chk("t3_readback_latency", 32'(ta - t0a), 32'd2);
        expect_ack(P_DBG, 32'd0);
        do_req(P_DBG, 1'b1, 10'd9, V_DB, t0a, ta);
        expect_ack(P_DBG, V_DB);
        do_req(P_DBG, 1'b0, 10'd9, 32'd0, t0a, ta);
        chk("t3_mem_write_dbg", mem[9], V_DB);

        // 4. Halt: only dbg is served, back to back every 3 cycles.
        halted = 1'b1;
        data_we = 1'b0; data_addr = 10'd3; data_req = 1'b1;
        fetch_addr = 10'd5; fetch_req = 1'b1;
        dbg_we = 1'b0; dbg_addr = 10'd7; dbg_req = 1'b1;
        t0a = cyc;
        repeat (3) expect_ack(P_DBG, V_A7);
        wait_ack(P_DBG, tprev);
        chk("t4_first_latency", 32'(tprev - t0a), 32'd2);
        for (int k = 0; k < 2; k++) begin
            wait_ack(P_DBG, tcur);
            chk("t4_dbg_interval", 32'(tcur - tprev), 32'd3);
            tprev = tcur;
        end
        @(posedge clk1); #1;
        data_req = 1'b0; fetch_req = 1'b0; dbg_req = 1'b0; halted = 1'b0;
        repeat (4) @(posedge clk1);
        #1;

        // 5. Data held continuously against a waiting dbg request.
        repeat (N_DATA_BEFORE_DBG) expect_ack(P_DATA, V_A1);
        expect_ack(P_DBG, V_A7);
        dbg_before = dbg_ack_cnt;
        data_we = 1'b0; data_addr = 10'd1; data_req = 1'b1;
        dbg_we = 1'b0; dbg_addr = 10'd7; dbg_req = 1'b1;
        for (int k = 0; k < N_DATA_BEFORE_DBG; k++) wait_ack(P_DATA, ta);
        chk("t5_no_dbg_while_data_held", 32'(dbg_ack_cnt - dbg_before), 32'd0);
`ifndef ARB_STARVE_GUARD_EN
        @(posedge clk1); #1;
        data_req = 1'b0;
`endif
        wait_ack(P_DBG, tb);
        chk("t5_dbg_after_data", 32'(tb - ta), 32'd3);
        @(posedge clk1); #1;
        data_req = 1'b0; dbg_req = 1'b0;

        // 6. Reset during the ISSUE cycle of a fetch.
        fetch_addr = 10'd5; fetch_req = 1'b1;
        @(posedge clk1); #1;
        chk("t6_in_issue", 32'(mem_en), 32'd1);
        rst_n = 1'b0; fetch_req = 1'b0;
        @(posedge clk1); #1;
        rst_n = 1'b1;
        nack = 0;
        repeat (5) begin
            @(negedge clk1);
            if (fetch_ack === 1'b1) nack++;
        end
        chk("t6_no_fetch_ack", 32'(nack), 32'd0);
        chk("t6_mem_en_idle", 32'(mem_en), 32'd0);
        @(posedge clk1); #1;
        expect_ack(P_FETCH, V_A5);
        do_req(P_FETCH, 1'b0, 10'd5, 32'd0, t0a, ta);
        chk("t6_idle_after_reset", 32'(ta - t0a), 32'd2);

        repeat (3) @(posedge clk1);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
